// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, access sizes,
// fault codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_ACCESS   = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Stores only have sized forms (SB/SH/SW); loads add the unsigned variants.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store)
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-data extender: sign or zero extends the right-justified
// read data according to the load's funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{rdata[7]}}, rdata[7:0]};
            F3_BU:   result = {24'd0, rdata[7:0]};
            F3_H:    result = {{16{rdata[15]}}, rdata[15:0]};
            F3_HU:   result = {16'd0, rdata[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store unit: validates one RV32I memory op, issues a single
// request to the memory controller and returns an extended result or a fault.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_LIMIT_BIT = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_store,
    input  logic [2:0]  op_funct3,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [1:0]  res_fault,
    output logic [31:0] mem_address,
    output logic        mem_rw_req,
    output logic        mem_rw,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_read_data,
    input  logic        mem_data_valid
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic        op_ready_q, op_ready_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_data_q, res_data_d;
    logic [1:0]  res_fault_q, res_fault_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_rw_req_q, mem_rw_req_d;
    logic        mem_rw_q, mem_rw_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic        store_q, store_d;

    logic [31:0] ext_data;
    logic [1:0]  chk_fault;

    lsu_extend u_extend (
        .funct3 (f3_q),
        .rdata  (mem_read_data),
        .result (ext_data)
    );

    // Priority: illegal funct3, then out-of-range address, then alignment.
    always_comb begin
        chk_fault = FLT_NONE;
        if (!f3_legal(op_store, op_funct3))
            chk_fault = FLT_ACCESS;
        else if (op_addr[ADDR_LIMIT_BIT])
            chk_fault = FLT_ACCESS;
        else if ((op_funct3[1:0] == SZ_HALF && op_addr[0]) ||
                 (op_funct3[1:0] == SZ_WORD && op_addr[1:0] != 2'b00))
            chk_fault = FLT_MISALIGN;
    end

    always_comb begin
        state_d          = state_q;
        op_ready_d       = op_ready_q;
        res_valid_d      = 1'b0;
        res_data_d       = res_data_q;
        res_fault_d      = res_fault_q;
        mem_address_d    = mem_address_q;
        mem_rw_req_d     = 1'b0;
        mem_rw_d         = mem_rw_q;
        mem_write_data_d = mem_write_data_q;
        mem_size_d       = mem_size_q;
        cnt_d            = cnt_q;
        f3_d             = f3_q;
        store_d          = store_q;

        case (state_q)
            ST_IDLE: begin
                op_ready_d = 1'b1;
                if (op_valid) begin
                    op_ready_d = 1'b0;
                    f3_d       = op_funct3;
                    store_d    = op_store;
                    if (chk_fault != FLT_NONE) begin
                        res_valid_d = 1'b1;
                        res_fault_d = chk_fault;
                        res_data_d  = '0;
                        state_d     = ST_RESP;
                    end else begin
                        mem_address_d    = op_addr;
                        mem_size_d       = op_funct3[1:0];
                        mem_rw_d         = op_store;
                        mem_write_data_d = op_wdata;
                        mem_rw_req_d     = 1'b1;
                        state_d          = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Data arriving on the final timeout cycle still wins.
                if (mem_data_valid) begin
                    res_valid_d = 1'b1;
                    res_fault_d = FLT_NONE;
                    res_data_d  = store_q ? 32'd0 : ext_data;
                    state_d     = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    res_valid_d = 1'b1;
                    res_fault_d = FLT_TIMEOUT;
                    res_data_d  = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                op_ready_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                op_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            op_ready_q       <= 1'b1;
            res_valid_q      <= 1'b0;
            res_data_q       <= '0;
            res_fault_q      <= FLT_NONE;
            mem_address_q    <= '0;
            mem_rw_req_q     <= 1'b0;
            mem_rw_q         <= 1'b0;
            mem_write_data_q <= '0;
            mem_size_q       <= SZ_BYTE;
            cnt_q            <= '0;
            f3_q             <= '0;
            store_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            op_ready_q       <= op_ready_d;
            res_valid_q      <= res_valid_d;
            res_data_q       <= res_data_d;
            res_fault_q      <= res_fault_d;
            mem_address_q    <= mem_address_d;
            mem_rw_req_q     <= mem_rw_req_d;
            mem_rw_q         <= mem_rw_d;
            mem_write_data_q <= mem_write_data_d;
            mem_size_q       <= mem_size_d;
            cnt_q            <= cnt_d;
            f3_q             <= f3_d;
            store_q          <= store_d;
        end
    end

    assign op_ready       = op_ready_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_fault      = res_fault_q;
    assign mem_address    = mem_address_q;
    assign mem_rw_req     = mem_rw_req_q;
    assign mem_rw         = mem_rw_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_size       = mem_size_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout and
// asynchronous reset, with hand-computed expected values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic        op_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        res_valid;
    logic [31:0] res_data;
    logic [1:0]  res_fault;
    logic [31:0] mem_address;
    logic        mem_rw_req;
    logic        mem_rw;
    logic [31:0] mem_write_data;
    logic [1:0]  mem_size;
    logic [31:0] mem_read_data;
    logic        mem_data_valid;

    int n_chk = 0;
    int n_err = 0;

    logic        g_valid;
    logic [31:0] g_data;
    logic [1:0]  g_fault;
    logic        g_req;
    int          g_pulses;
    logic        g_hold;
    logic [31:0] g_addr;
    logic [1:0]  g_size;
    logic        g_rw;
    logic [31:0] g_wdata;
    int          to_cnt;

    load_store_unit #(.TIMEOUT_CYCLES(64), .ADDR_LIMIT_BIT(31)) dut (
        .clk            (clk),
        .reset          (reset),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_store       (op_store),
        .op_funct3      (op_funct3),
        .op_addr        (op_addr),
        .op_wdata       (op_wdata),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_fault      (res_fault),
        .mem_address    (mem_address),
        .mem_rw_req     (mem_rw_req),
        .mem_rw         (mem_rw),
        .mem_write_data (mem_write_data),
        .mem_size       (mem_size),
        .mem_read_data  (mem_read_data),
        .mem_data_valid (mem_data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op; for a legal op the controller answers after wait_cyc cycles.
    task automatic lsu_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int wait_cyc, input logic [31:0] rd);
        op_valid  = 1'b1;
        op_store  = st;
        op_funct3 = f3;
        op_addr   = addr;
        op_wdata  = wd;
        tick();
        op_valid = 1'b0;
        g_req    = mem_rw_req;
        g_pulses = mem_rw_req ? 1 : 0;
        g_hold   = 1'b1;
        g_addr   = mem_address;
        g_size   = mem_size;
        g_rw     = mem_rw;
        g_wdata  = mem_write_data;
        if (res_valid) begin
            g_valid = res_valid;
            g_data  = res_data;
            g_fault = res_fault;
            tick();
        end else begin
            for (int i = 0; i < wait_cyc; i++) begin
                tick();
                if (mem_rw_req) g_pulses++;
                if (mem_address !== g_addr || mem_size !== g_size ||
                    mem_rw !== g_rw || mem_write_data !== g_wdata) g_hold = 1'b0;
            end
            mem_read_data  = rd;
            mem_data_valid = 1'b1;
            tick();
            mem_data_valid = 1'b0;
            g_valid = res_valid;
            g_data  = res_data;
            g_fault = res_fault;
            if (mem_address !== g_addr || mem_rw !== g_rw ||
                mem_write_data !== g_wdata) g_hold = 1'b0;
            tick();
        end
    endtask

    initial begin
        reset          = 1'b0;
        op_valid       = 1'b0;
        op_store       = 1'b0;
        op_funct3      = 3'd0;
        op_addr        = 32'd0;
        op_wdata       = 32'd0;
        mem_read_data  = 32'd0;
        mem_data_valid = 1'b0;
        repeat (3) tick();

        check("rst_op_ready",  32'(op_ready),   32'd1);
        check("rst_res_valid", 32'(res_valid),  32'd0);
        check("rst_rw_req",    32'(mem_rw_req), 32'd0);
        check("rst_addr",      mem_address,     32'd0);
        check("rst_size",      32'(mem_size),   32'd0);
        check("rst_res_data",  res_data,        32'd0);
        reset = 1'b1;
        tick();

        lsu_op(1'b0, 3'b010, 32'h0000_0100, 32'd0, 6, 32'hDEAD_BEEF);
        check("lw_req_n1",  32'(g_req),   32'd1);
        check("lw_pulses",  32'(g_pulses), 32'd1);
        check("lw_size",    32'(g_size),  32'd2);
        check("lw_rw",      32'(g_rw),    32'd0);
        check("lw_addr",    g_addr,       32'h0000_0100);
        check("lw_valid",   32'(g_valid), 32'd1);
        check("lw_data",    g_data,       32'hDEAD_BEEF);
        check("lw_fault",   32'(g_fault), 32'd0);
        check("lw_idle_rdy", 32'(op_ready), 32'd1);
        check("lw_idle_vld", 32'(res_valid), 32'd0);

        lsu_op(1'b0, 3'b000, 32'h0000_0103, 32'd0, 3, 32'h0000_0080);
        check("lb_data",  g_data, 32'hFFFF_FF80);
        check("lb_size",  32'(g_size), 32'd0);
        lsu_op(1'b0, 3'b100, 32'h0000_0103, 32'd0, 3, 32'h0000_0080);
        check("lbu_data", g_data, 32'h0000_0080);
        lsu_op(1'b0, 3'b001, 32'h0000_0102, 32'd0, 2, 32'h0000_8001);
        check("lh_data",  g_data, 32'hFFFF_8001);
        lsu_op(1'b0, 3'b101, 32'h0000_0102, 32'd0, 2, 32'h0000_8001);
        check("lhu_data", g_data, 32'h0000_8001);

        lsu_op(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5, 32'hFFFF_FFFF);
        check("sh_size",  32'(g_size), 32'd1);
        check("sh_rw",    32'(g_rw),   32'd1);
        check("sh_wdata", g_wdata,     32'h1234_ABCD);
        check("sh_hold",  32'(g_hold), 32'd1);
        check("sh_valid", 32'(g_valid), 32'd1);
        check("sh_data",  g_data,      32'd0);
        check("sh_fault", 32'(g_fault), 32'd0);

        lsu_op(1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 32'd0);
        check("mis_valid",  32'(g_valid), 32'd1);
        check("mis_fault",  32'(g_fault), 32'd1);
        check("mis_req",    32'(g_pulses), 32'd0);
        check("mis_data",   g_data, 32'd0);
        lsu_op(1'b0, 3'b010, 32'h8000_0000, 32'd0, 0, 32'd0);
        check("rng_fault",  32'(g_fault), 32'd2);
        check("rng_req",    32'(g_pulses), 32'd0);
        lsu_op(1'b0, 3'b011, 32'h0000_0100, 32'd0, 0, 32'd0);
        check("f3_fault",   32'(g_fault), 32'd2);
        check("f3_req",     32'(g_pulses), 32'd0);
        lsu_op(1'b1, 3'b100, 32'h0000_0100, 32'd0, 0, 32'd0);
        check("sf3_fault",  32'(g_fault), 32'd2);
        lsu_op(1'b0, 3'b010, 32'h8000_0001, 32'd0, 0, 32'd0);
        check("prio_fault", 32'(g_fault), 32'd2);
        lsu_op(1'b0, 3'b001, 32'h0000_0103, 32'd0, 0, 32'd0);
        check("lh_mis",     32'(g_fault), 32'd1);

        // Data on the last timeout cycle beats the timeout.
        lsu_op(1'b0, 3'b010, 32'h0000_0300, 32'd0, 64, 32'h0BAD_F00D);
        check("edge_valid", 32'(g_valid), 32'd1);
        check("edge_fault", 32'(g_fault), 32'd0);
        check("edge_data",  g_data, 32'h0BAD_F00D);

        op_valid  = 1'b1;
        op_store  = 1'b0;
        op_funct3 = 3'b010;
        op_addr   = 32'h0000_0040;
        tick();
        op_valid = 1'b0;
        tick();
        to_cnt = 0;
        while (!res_valid && to_cnt < 100) begin
            tick();
            to_cnt++;
        end
        check("to_cycles", 32'(to_cnt), 32'd64);
        check("to_fault",  32'(res_fault), 32'd3);
        check("to_data",   res_data, 32'd0);
        tick();
        mem_read_data  = 32'h5555_5555;
        mem_data_valid = 1'b1;
        tick();
        mem_data_valid = 1'b0;
        check("stray_valid", 32'(res_valid), 32'd0);
        check("stray_ready", 32'(op_ready),  32'd1);
        tick();
        check("stray_valid2", 32'(res_valid), 32'd0);
        lsu_op(1'b0, 3'b010, 32'h0000_0044, 32'd0, 4, 32'hCAFE_0001);
        check("post_to_data",  g_data, 32'hCAFE_0001);
        check("post_to_fault", 32'(g_fault), 32'd0);

        op_valid  = 1'b1;
        op_store  = 1'b1;
        op_funct3 = 3'b010;
        op_addr   = 32'h0000_0500;
        op_wdata  = 32'hA5A5_A5A5;
        tick();
        op_valid = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        check("ar_ready",  32'(op_ready),   32'd1);
        check("ar_valid",  32'(res_valid),  32'd0);
        check("ar_addr",   mem_address,     32'd0);
        check("ar_rw",     32'(mem_rw),     32'd0);
        check("ar_wdata",  mem_write_data,  32'd0);
        check("ar_size",   32'(mem_size),   32'd0);
        mem_data_valid = 1'b1;
        tick();
        mem_data_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("ar_no_resp", 32'(res_valid), 32'd0);
        mem_data_valid = 1'b1;
        tick();
        mem_data_valid = 1'b0;
        check("ar_stray", 32'(res_valid), 32'd0);
        lsu_op(1'b0, 3'b100, 32'h0000_0007, 32'd0, 2, 32'h0000_00FE);
        check("ar_post_data",  g_data, 32'h0000_00FE);
        check("ar_post_fault", 32'(g_fault), 32'd0);
        check("ar_post_pulse", 32'(g_pulses), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the SRAM memory-controller request interface: the CPU-facing load/store unit.
- Accepts one RV32I load/store op at a time from the execute stage and validates alignment, range and funct3.
- Issues a single-cycle rw_req to the memory controller, waits for data_valid, then returns a sign- or zero-extended result or a fault.
- Sits between the core pipeline and the memory controller, on the data path only.

Parameters:
- TIMEOUT_CYCLES, 64: cycles in WAIT without mem_data_valid before a timeout fault is raised. Legal range 2..255.
- ADDR_LIMIT_BIT, 31: an address with this bit set is outside the memory controller's space and raises an access fault.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  an op is presented
- op_ready  out  1  LSU is in IDLE and can accept an op
- op_store  in  1  1 = store, 0 = load
- op_funct3  in  3  RV32I funct3 (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB/SH/SW=000/001/010)
- op_addr  in  32  byte address
- op_wdata  in  32  store data, value in the low bits
- res_valid  out  1  one-cycle completion pulse
- res_data  out  32  extended load data; 0 for stores and faults
- res_fault  out  2  0 none, 1 misaligned, 2 access, 3 timeout
- mem_address  out  32  request address
- mem_rw_req  out  1  request strobe
- mem_rw  out  1  1 = write
- mem_write_data  out  32  write data
- mem_size  out  2  0 byte, 1 half, 2 word
- mem_read_data  in  32  read data, right-justified, upper bits zero
- mem_data_valid  in  1  one-cycle completion from the memory controller

Behaviour:
- Reset values: state=IDLE, op_ready=1, res_valid=0, res_data=0, res_fault=0, mem_rw_req=0, mem_rw=0, mem_address=0, mem_write_data=0, mem_size=0, timeout counter=0.
- All outputs are registered.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - op_ready=1.
  - On op_valid, latch the op and check it in priority order:
    - Illegal funct3 (011, 110, 111 for loads; any value >=011 for stores) -> fault 2.
    - op_addr[ADDR_LIMIT_BIT]=1 -> fault 2.
    - Half with addr[0]=1, or word with addr[1:0]!=0 -> fault 1.
  - Any fault -> RESP with that code; no memory request is issued.
  - Otherwise drive mem_address, mem_size (funct3[1:0]), mem_rw=op_store and mem_write_data=op_wdata, then go to REQ.
- REQ:
  - mem_rw_req=1 for exactly this cycle; go to WAIT.
  - mem_address, mem_rw, mem_size and mem_write_data are held stable from REQ until RESP ends, because the memory controller samples mem_rw late in the transaction.
- WAIT:
  - mem_rw_req=0 and the counter increments each cycle.
  - On mem_data_valid: capture and extend the data, go to RESP.
  - When the counter reaches TIMEOUT_CYCLES-1 with no mem_data_valid: fault 3, go to RESP.
  - If mem_data_valid coincides with the timeout cycle, the data wins and no fault is raised.
- Extension rules:
  - LB: sign-extend [7:0]; LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]; LHU: zero-extend [15:0].
  - LW: pass through unchanged.
  - Stores: res_data=0.
- RESP:
  - res_valid=1 for one cycle, then go to IDLE.
  - This cycle overlaps the memory controller's post-valid recovery cycle, so the next possible REQ is 2 cycles after RESP and never collides with it.
- Latency: op accepted at edge N, mem_rw_req high in cycle N+1, res_valid in the cycle after the mem_data_valid edge. A faulted op gives res_valid in cycle N+1.
- mem_data_valid in IDLE, REQ or RESP (late or stray) is ignored.
- Reset asserted mid-operation: immediate return to reset values. Any response still in flight from the memory controller is then ignored.
- op_valid outside IDLE is ignored; the upstream stage must hold the op until op_ready.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams
  - size codes (SZ_BYTE, SZ_HALF, SZ_WORD)
  - fault codes (FLT_NONE, FLT_MISALIGN, FLT_ACCESS, FLT_TIMEOUT)
  - state encoding
- Sub-module lsu_extend: combinational extender taking funct3 and mem_read_data, producing the 32-bit result.
- The FSM, checks and timeout counter stay in load_store_unit.

Test Plan:
- LW at addr 0x100, controller returns 0xDEADBEEF after 6 cycles -> one rw_req pulse with size=2, rw=0; then res_valid with res_data=0xDEADBEEF, fault 0.
- LB at 0x103 returning 0x00000080 -> res_data=0xFFFFFF80; the same access as LBU -> res_data=0x00000080.
- SH at 0x202 with wdata 0x1234ABCD -> mem_size=1, mem_rw=1, mem_write_data=0x1234ABCD held until mem_data_valid; then res_data=0.
- LW at 0x101 -> fault 1 in cycle N+1; address 0x80000000 -> fault 2; funct3=011 -> fault 2; mem_rw_req stays 0 in all three cases.
- Controller never responds -> fault 3 after 64 WAIT cycles; a stray mem_data_valid afterwards is ignored, and the next LW completes normally.
- Reset asserted in WAIT -> all outputs return to reset values asynchronously with no res_valid; after reset is released a new op completes normally.
